dma_fly_controller: RTL and testbench

- Fly-by DMA controller that moves words between N_DEV IO devices and main memory over the shared 32-bit Data bus.
- The DMA never latches data. It arbitrates device interrupt requests (GPIO lines), requests bus mastership from the CPU, then drives device acks, the device direction line and memory address/strobes.
- Sits between the IO devices, the memory, and the CPU's bus hold/grant logic. The CPU programs it through a small register interface.

---
 rtl/dma_pkg.sv | 21 ++
 rtl/dma_fly_controller_if.sv | 30 +++
 rtl/dma_rr_arbiter.sv | 24 ++
 rtl/dma_fly_controller.sv | 146 ++++++++++++++
 tb/tb_dma_fly_controller.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the fly-by DMA controller: FSM encoding, register map, ctrl bits.
package dma_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] REG_BASE = 2'd0;
    localparam logic [1:0] REG_LEN  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_DIR = 1;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_fly_controller_if.sv
// Device, memory, bus-hold and CPU register signals of the fly-by DMA controller.
interface dma_fly_controller_if import dma_pkg::*; #(
    parameter int N_DEV  = 2,
    parameter int ADDR_W = 9,
    parameter int CH_W   = ch_w(N_DEV)
);
    logic [N_DEV-1:0]  gpio;
    logic [N_DEV-1:0]  ack;
    logic              io_write;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic              bus_req;
    logic              bus_gnt;
    logic              cfg_we;
    logic [CH_W+1:0]   cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    logic [N_DEV-1:0]  done_irq;

    modport master (
        input  gpio, bus_gnt, cfg_we, cfg_addr, cfg_wdata,
        output ack, io_write, mem_addr, mem_we, mem_re, bus_req, cfg_rdata, done_irq
    );

    modport slave (
        output gpio, bus_gnt, cfg_we, cfg_addr, cfg_wdata,
        input  ack, io_write, mem_addr, mem_we, mem_re, bus_req, cfg_rdata, done_irq
    );
endinterface

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward starting just after the last grant.
module dma_rr_arbiter #(
    parameter int N_DEV = 2,
    parameter int CH_W  = 1
) (
    input  logic [N_DEV-1:0] req,
    input  logic [CH_W-1:0]  last,
    output logic [N_DEV-1:0] gnt,
    output logic             valid
);
    always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        valid = 1'b0;
        for (int k = 1; k <= N_DEV; k++) begin
            idx = (int'(last) + k) % N_DEV;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dma_fly_controller.sv
// Fly-by DMA controller: arbitrates device requests, holds the CPU bus, sequences memory strobes.
// Optional status readback on cfg_rdata is built when DMA_STATUS_READBACK_EN is defined.
module dma_fly_controller import dma_pkg::*; #(
    parameter int N_DEV  = 2,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 5
) (
    input logic clk,
    input logic rst_n,
    dma_fly_controller_if.master bus
);
    localparam int CH_W = ch_w(N_DEV);

    logic [ADDR_W-1:0] base_r [N_DEV];
    logic [LEN_W-1:0]  len_r  [N_DEV];
    logic [N_DEV-1:0]  en_r, dir_r;

    logic [1:0]        state;
    logic [CH_W-1:0]   cur, ptr, sel, cfg_ch;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              dir, stop, locked, cfg_ch_ok;
    logic [N_DEV-1:0]  arb_gnt;
    logic              arb_valid;
    logic              cfg_unused;

    dma_rr_arbiter #(.N_DEV(N_DEV), .CH_W(CH_W)) u_arb (
        .req   (bus.gpio & en_r),
        .last  (ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_DEV; i++)
            if (arb_gnt[i]) sel = CH_W'(i);
    end

    assign cfg_ch     = bus.cfg_addr[CH_W+1:2];
    assign cfg_ch_ok  = int'(cfg_ch) < N_DEV;
    assign locked     = (state != ST_IDLE) && (cfg_ch == cur);
    assign cfg_unused = ^bus.cfg_wdata;

    // The active channel is frozen while busy, except that its enable may be cleared to abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DEV; i++) begin
                base_r[i] <= '0;
                len_r[i]  <= '0;
            end
            en_r  <= '0;
            dir_r <= '0;
        end else if (bus.cfg_we && cfg_ch_ok) begin
            case (bus.cfg_addr[1:0])
                REG_BASE: if (!locked) base_r[cfg_ch] <= bus.cfg_wdata[ADDR_W-1:0];
                REG_LEN:  if (!locked) len_r[cfg_ch]  <= bus.cfg_wdata[LEN_W-1:0];
                REG_CTRL: begin
                    if (!locked) begin
                        en_r[cfg_ch]  <= bus.cfg_wdata[CTRL_EN];
                        dir_r[cfg_ch] <= bus.cfg_wdata[CTRL_DIR];
                    end else begin
                        en_r[cfg_ch]  <= en_r[cfg_ch] & bus.cfg_wdata[CTRL_EN];
                    end
                end
                default: ;
            endcase
        end
    end

    // Early termination: channel disabled, or a dev->mem device whose buffer has drained.
    assign stop = ~en_r[cur] | (~dir & ~bus.gpio[cur]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur       <= '0;
            ptr       <= '0;
            addr      <= '0;
            remaining <= '0;
            dir       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (arb_valid) begin
                    cur       <= sel;
                    addr      <= base_r[sel];
                    remaining <= len_r[sel];
                    dir       <= dir_r[sel];
                    state     <= (len_r[sel] == '0) ? ST_DONE : ST_REQ;
                end
                ST_REQ: begin
                    if (!en_r[cur])      state <= ST_DONE;
                    else if (bus.bus_gnt) state <= ST_XFER;
                end
                ST_XFER: begin
                    if (bus.bus_gnt) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1) || stop) state <= ST_DONE;
                    end else if (stop) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    ptr   <= cur;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    always_comb begin
        bus.ack      = '0;
        bus.done_irq = '0;
        if (state == ST_XFER) bus.ack[cur]      = 1'b1;
        if (state == ST_DONE) bus.done_irq[cur] = 1'b1;
    end

    assign bus.bus_req  = (state == ST_REQ) || (state == ST_XFER);
    assign bus.io_write = (state == ST_XFER) ? dir : 1'b1;
    assign bus.mem_addr = (state == ST_XFER) ? addr : '0;
    assign bus.mem_we   = (state == ST_XFER) && bus.bus_gnt && !dir;
    assign bus.mem_re   = (state == ST_XFER) && bus.bus_gnt && dir;

`ifdef DMA_STATUS_READBACK_EN
    always_comb begin
        bus.cfg_rdata = '0;
        if (cfg_ch_ok) begin
            case (bus.cfg_addr[1:0])
                REG_BASE: bus.cfg_rdata[ADDR_W-1:0] = base_r[cfg_ch];
                REG_LEN:  bus.cfg_rdata[LEN_W-1:0]  = len_r[cfg_ch];
                REG_CTRL: begin
                    bus.cfg_rdata[CTRL_EN]  = en_r[cfg_ch];
                    bus.cfg_rdata[CTRL_DIR] = dir_r[cfg_ch];
                end
                default: if (state != ST_IDLE && cur == cfg_ch)
                    bus.cfg_rdata[LEN_W:0] = {remaining, 1'b1};
            endcase
        end
    end
`else
    assign bus.cfg_rdata = '0;
`endif

endmodule

// File: tb/tb_dma_fly_controller.sv
// Randomized self-checking bench for dma_fly_controller against a word-sequence reference model.
module tb_dma_fly_controller;
    localparam int N_DEV  = 2;
    localparam int ADDR_W = 9;
    localparam int LEN_W  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    dma_fly_controller_if #(.N_DEV(N_DEV), .ADDR_W(ADDR_W), .CH_W(1)) dif ();

    dma_fly_controller #(.N_DEV(N_DEV), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called and returns at one time unit after a rising edge.
    task automatic cfg_write(input int ch, input int rg, input int data);
        dif.cfg_we    = 1'b1;
        dif.cfg_addr  = {1'(ch), 2'(rg)};
        dif.cfg_wdata = 32'(data);
        @(posedge clk); #1;
        dif.cfg_we    = 1'b0;
    endtask

    // Reference: a transfer moves min(len, early) words at (base+k) mod 2^ADDR_W.
    task automatic run_xfer(input int ch, input int base, input int len, input bit dir,
                            input int mode, input int early_at, input string name);
        int  exp_n, cnt, first_req, first_gnt, first_strb, drop_left;
        bit  done, dropped, req_seen;
        logic req_now;
        logic [ADDR_W-1:0] exp_addr;
        cfg_write(ch, 0, base);
        cfg_write(ch, 1, len);
        cfg_write(ch, 2, {30'd0, dir, 1'b1});
        dif.gpio[ch] = 1'b1;
        exp_n = (early_at > 0 && early_at < len) ? early_at : len;
        cnt = 0; first_req = -1; first_gnt = -1; first_strb = -1; drop_left = 0;
        done = 0; dropped = 0; req_seen = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            req_now = dif.bus_req;
            if (dif.bus_req) begin
                req_seen = 1;
                if (first_req < 0) first_req = cyc;
            end
            if (dif.bus_gnt && first_gnt < 0) first_gnt = cyc;
            if (dif.mem_we || dif.mem_re) begin
                if (first_strb < 0) first_strb = cyc;
                exp_addr = ADDR_W'((base + cnt) % (1 << ADDR_W));
                check({name, " addr"}, 32'(dif.mem_addr), 32'(exp_addr));
                check({name, " dir"}, 32'({dif.mem_re, dif.mem_we, dif.io_write}),
                      32'({dir, !dir, dir}));
                check({name, " ack"}, 32'(dif.ack), 32'(1 << ch));
                check({name, " strobe gnt"}, 32'(dif.bus_gnt), 32'd1);
                cnt++;
            end else if (dif.ack != '0 && !dif.bus_gnt) begin
                check({name, " gate"}, 32'({dif.mem_we, dif.mem_re, dif.bus_req}), 32'b001);
            end
            if (dif.done_irq != '0) begin
                check({name, " done"}, 32'(dif.done_irq), 32'(1 << ch));
                done = 1;
            end
            if (mode == 2 && cnt == 2 && !dropped) begin
                dropped = 1;
                drop_left = 3;
            end
            @(posedge clk); #1;
            if (early_at > 0 && cnt == early_at - 1) dif.gpio[ch] = 1'b0;
            case (mode)
                1:       dif.bus_gnt = req_now && ($urandom_range(3) != 0);
                2:       if (drop_left > 0) begin dif.bus_gnt = 1'b0; drop_left--; end
                         else dif.bus_gnt = req_now;
                default: dif.bus_gnt = req_now;
            endcase
        end
        dif.gpio[ch] = 1'b0;
        dif.bus_gnt  = 1'b0;
        check({name, " completed"}, 32'(done), 32'd1);
        check({name, " words"}, 32'(cnt), 32'(exp_n));
        if (len == 0) check({name, " no bus_req"}, 32'(req_seen), 32'd0);
        if (mode == 0 && len > 0) begin
            check({name, " req latency"}, 32'(first_req), 32'd1);
            check({name, " gnt->strobe"}, 32'(first_strb - first_gnt), 32'd1);
        end
        @(negedge clk);
        check({name, " done pulse width"}, 32'(dif.done_irq), 32'd0);
        check({name, " idle bus_req"}, 32'(dif.bus_req), 32'd0);
        @(posedge clk); #1;
        cfg_write(ch, 2, 0);
    endtask

    initial begin
        logic req_any;
        int   ndone, exp_ch, got_ch, cnt;
        dif.gpio = '0; dif.bus_gnt = 1'b0; dif.cfg_we = 1'b0;
        dif.cfg_addr = '0; dif.cfg_wdata = '0;
        #1;
        check("reset outputs", 32'({dif.ack, dif.mem_we, dif.mem_re, dif.bus_req, dif.io_write}),
              32'b00_0001);
        check("reset addr/irq", 32'({dif.mem_addr, dif.done_irq}), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        run_xfer(0, 'h040, 5, 1'b0, 0, 0, "single d2m");
        run_xfer(0, 'h0A0, 6, 1'b1, 2, 0, "preempt m2d");
        run_xfer(0, 'h010, 10, 1'b0, 0, 4, "early end");
        run_xfer(1, 'h020, 0, 1'b0, 0, 0, "len0");
        run_xfer(1, 'h1FE, 4, 1'b1, 0, 0, "wrap");
        for (int t = 0; t < 6; t++)
            run_xfer(int'($urandom_range(N_DEV-1)), int'($urandom_range(511)),
                     int'($urandom_range(31, 1)), 1'($urandom_range(1)), 1, 0, "random");

        // Round-robin with both devices requesting continuously.
        dif.gpio = 2'b11;
        cfg_write(0, 0, 'h100); cfg_write(0, 1, 2);
        cfg_write(1, 0, 'h180); cfg_write(1, 1, 2);
        cfg_write(0, 2, 1);     cfg_write(1, 2, 1);
        ndone = 0; exp_ch = 0;
        for (int cyc = 0; cyc < 200 && ndone < 4; cyc++) begin
            @(negedge clk);
            req_any = dif.bus_req;
            if (dif.done_irq != '0) begin
                got_ch = dif.done_irq[1] ? 1 : 0;
                check("rr onehot", 32'($countones(dif.done_irq)), 32'd1);
                check("rr order", 32'(got_ch), 32'(exp_ch));
                exp_ch = (exp_ch + 1) % N_DEV;
                ndone++;
            end
            @(posedge clk); #1;
            dif.bus_gnt = req_any;
        end
        dif.gpio = '0; dif.bus_gnt = 1'b0;
        check("rr count", 32'(ndone), 32'd4);
        cfg_write(0, 2, 0); cfg_write(1, 2, 0);

`ifdef DMA_STATUS_READBACK_EN
        cfg_write(1, 0, 'h0AB);
        dif.cfg_addr = {1'b1, 2'd0}; #1;
        check("readback base", dif.cfg_rdata, 32'h0AB);
`else
        cfg_write(1, 0, 'h0AB);
        dif.cfg_addr = {1'b1, 2'd0}; #1;
        check("readback tied", dif.cfg_rdata, 32'h0);
`endif
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a dev->mem transfer.
        cfg_write(0, 0, 'h100); cfg_write(0, 1, 10); cfg_write(0, 2, 1);
        dif.gpio[0] = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 100 && cnt < 3; cyc++) begin
            @(negedge clk);
            req_any = dif.bus_req;
            if (dif.mem_we) cnt++;
            @(posedge clk); #1;
            dif.bus_gnt = req_any;
        end
        check("rst pre words", 32'(cnt), 32'd3);
        check("rst pre active", 32'({dif.ack[0], dif.bus_req}), 32'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rst async outputs", 32'({dif.ack, dif.mem_we, dif.bus_req, dif.io_write}),
              32'b00_001);
        dif.bus_gnt = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        req_any = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            req_any = req_any | dif.bus_req;
        end
        check("rst no restart", 32'(req_any), 32'd0);
        @(posedge clk); #1;
        dif.gpio = '0;
        run_xfer(0, 'h033, 3, 1'b0, 0, 0, "post reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
